tristate_bus_arbiter: RTL
=========================

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one tristate bus (legal range 2..8).
REQ-002 Parameter HOLD_MAX, default 8, SHALL set the maximum number of consecutive cycles one owner may hold the bus (legal range 1..255).
REQ-003 Parameter TURN_CYC, default 1, SHALL set the number of dead cycles between two owners (legal range 1..4).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req  input  NREQ  SHALL carry one level-sensitive bus request per requester; bit i belongs to requester i.
REQ-007 grant  output  NREQ  SHALL be one-hot-or-zero and mark the current bus owner.
REQ-008 drv_en  output  NREQ  SHALL be one-hot-or-zero and drive the ctl pin of each requester's bufif1 driver.
REQ-009 bus_idle  output  1  SHALL be high when no driver is enabled and the bus floats to its pullup.
REQ-010 timeout  output  1  SHALL pulse high for one cycle when an owner is forcibly released at HOLD_MAX.

Function
REQ-011 The controller SHALL have three states: IDLE (no owner, bus floating), OWN (one owner driving), TURN (dead time, bus floating).
REQ-012 All outputs SHALL be registered.
REQ-013 grant and drv_en SHALL always be equal, and at most one bit of each SHALL ever be set.
REQ-014 IDLE -> OWN: if any req bit is high at edge t, the winner's grant/drv_en bit SHALL be high from edge t+1.
REQ-015 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod NREQ; after reset last_owner = NREQ-1, so requester 0 has first priority.
REQ-016 OWN -> TURN: when the owner's req bit is low at an edge, grant/drv_en SHALL clear at that edge.
REQ-017 OWN -> TURN: when the owner has held the bus HOLD_MAX cycles, grant/drv_en SHALL clear at that edge, regardless of req; timeout SHALL pulse for that one cycle.
REQ-018 The hold counter SHALL load 1 on entry to OWN, increment each OWN cycle, and saturate at HOLD_MAX. It SHALL never wrap.
REQ-019 TURN SHALL last exactly TURN_CYC cycles with drv_en all zero.
REQ-020 On TURN exit the controller SHALL arbitrate like IDLE. It goes to OWN (grant visible on the exit edge) if any req is high, else to IDLE.
REQ-021 A timed-out requester still asserting req SHALL lose to any other active requester. If it is the only requester it SHALL be re-granted after the turnaround.
REQ-022 Requests that change during TURN SHALL be sampled only at the TURN-exit edge; requests asserted and dropped inside TURN SHALL be ignored.
REQ-023 Changes to req bits of non-owners during OWN SHALL NOT affect the current owner.
REQ-024 bus_idle SHALL be high exactly when drv_en is all zero.
REQ-025 Owner-to-owner handover SHALL never have fewer than TURN_CYC cycles with drv_en all zero; two drv_en bits SHALL never be high in the same cycle.

Reset
REQ-026 Asserting reset SHALL, asynchronously and without waiting for clk:
- force state to IDLE;
- force grant=0, drv_en=0, timeout=0, bus_idle=1, hold counter=0, last_owner=NREQ-1.
REQ-027 Reset asserted mid-OWN SHALL release the bus immediately.
REQ-028 On the first edge after reset deasserts, the controller SHALL arbitrate normally from IDLE.

Verification
REQ-029 Reset, then req=4'b0100 held at edge 0 -> grant=drv_en=4'b0100 from edge 1, bus_idle=0.
REQ-030 req=4'b1111 held continuously, HOLD_MAX=8, TURN_CYC=1 -> owners in order 0,1,2,3,0:
- each owner holds 8 cycles;
- timeout pulses each handover;
- exactly 1 cycle of drv_en=0 between owners.
REQ-031 Owner 1 drops req after 3 cycles while req[3] is high -> drv_en clears at the drop edge, one dead cycle, then grant=4'b1000; timeout stays 0.
REQ-032 Only req[2] is held for 20 cycles (HOLD_MAX=8) -> pattern 8 on / 1 off / 8 on / ...; timeout pulses at each forced release.
REQ-033 reset asserted between edges while grant=4'b0010 -> grant=drv_en=0 and bus_idle=1 immediately; after deassert with req=4'b0010, grant is restored on the next edge.
REQ-034 An assertion checker SHALL run on every test and flag:
- onehot0(drv_en) false;
- grant != drv_en;
- bus_idle != (drv_en==0);
- any handover with fewer than TURN_CYC zero cycles.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus with bounded hold time
// and guaranteed dead cycles between owners; every output is registered.
module tristate_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] drv_en,
    output logic            bus_idle,
    output logic            timeout
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t          r_state, w_state_nx;
    logic [NREQ-1:0] r_grant, w_grant_nx;
    logic            r_timeout, w_timeout_nx;
    logic            r_idle;
    logic [7:0]      r_hold, w_hold_nx;
    logic [2:0]      r_turn, w_turn_nx;
    logic [IW-1:0]   r_last, w_last_nx;
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic [IW:0]     w_cand;
    logic [NREQ-1:0] w_shift;
    logic            w_owner_req;

    // Search starts just after the previous owner, so it has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        w_shift = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_last} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(NREQ))
                w_cand = w_cand - (IW+1)'(NREQ);
            w_shift = req >> w_cand;
            if (!w_found && w_shift[0]) begin
                w_found = 1'b1;
                w_win   = w_cand[IW-1:0];
            end
        end
    end

    assign w_owner_req = |(req & r_grant);

    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_timeout_nx = 1'b0;
        w_hold_nx    = r_hold;
        w_turn_nx    = r_turn;
        w_last_nx    = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_OWN;
                    w_grant_nx = NREQ'(1) << w_win;
                    w_hold_nx  = 8'd1;
                    w_last_nx  = w_win;
                end
            end
            S_OWN: begin
                if (!w_owner_req || r_hold >= 8'(HOLD_MAX)) begin
                    w_state_nx   = S_TURN;
                    w_grant_nx   = '0;
                    w_turn_nx    = 3'd1;
                    w_hold_nx    = '0;
                    // A voluntary release on the last allowed cycle is not a timeout.
                    w_timeout_nx = w_owner_req;
                end else begin
                    w_hold_nx = r_hold + 8'd1;
                end
            end
            S_TURN: begin
                if (r_turn >= 3'(TURN_CYC)) begin
                    w_turn_nx = '0;
                    if (w_found) begin
                        w_state_nx = S_OWN;
                        w_grant_nx = NREQ'(1) << w_win;
                        w_hold_nx  = 8'd1;
                        w_last_nx  = w_win;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_turn_nx = r_turn + 3'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_timeout <= 1'b0;
            r_idle    <= 1'b1;
            r_hold    <= '0;
            r_turn    <= '0;
            r_last    <= IW'(NREQ-1);
        end else begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_timeout <= w_timeout_nx;
            r_idle    <= ~|w_grant_nx;
            r_hold    <= w_hold_nx;
            r_turn    <= w_turn_nx;
            r_last    <= w_last_nx;
        end
    end

    assign grant    = r_grant;
    assign drv_en   = r_grant;
    assign bus_idle = r_idle;
    assign timeout  = r_timeout;

endmodule
